// File: rtl/stall_ctrl.sv
// ---------------------------------------------------------------------------
// stall_ctrl
//
// Central pipeline stall controller for the 5-stage core. It merges the
// ID-stage load-use hazard request with an internal sequencer that holds the
// front of the pipeline while a multi-cycle multiply or divide sits in EX.
//
// Stall bus encoding (one bit per pipeline register):
//   stall[0] PC, stall[1] IF/ID, stall[2] ID/EX, stall[3] EX/MEM,
//   stall[4] MEM/WB, stall[5] WB.
//   stall[i]=1 with stall[i+1]=0 inserts a bubble into stage i+1.
//
// Ports:
//   clk          in   core clock
//   rst          in   synchronous active-high reset
//   stallreq_id  in   load-use hazard from ID (same-cycle request)
//   md_start     in   EX holds a mult/div instruction this cycle
//   md_is_div    in   qualifies md_start: 1=div, 0=mult
//   md_done      in   divider result valid (1-cycle pulse)
//   stall        out  stall bus (combinational, same-cycle response)
//   md_busy      out  sequencer is not in RUN
//   md_timeout   out  sticky flag, divider watchdog fired
//   stall_cycles out  saturating count of cycles with stall[0]=1
// ---------------------------------------------------------------------------
module stall_ctrl #(
    parameter int STALL_W    = 6,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_WDT    = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               md_start,
    input  logic               md_is_div,
    input  logic               md_done,
    output logic [STALL_W-1:0] stall,
    output logic               md_busy,
    output logic               md_timeout,
    output logic [31:0]        stall_cycles
);

    // Sequencer states
    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_MUL = 2'd1;
    localparam logic [1:0] ST_DIV = 2'd2;

    // Counter widths; at least one bit even for the smallest legal parameters
    localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
    localparam int WDT_W = (DIV_WDT > 2) ? $clog2(DIV_WDT) : 1;

    // The RUN cycle that accepts the op is already a stall cycle, so the
    // busy state only needs MUL_CYCLES-2 further hold cycles before release.
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MUL_CYCLES - 2);
    localparam logic [WDT_W-1:0] WDT_LAST  = WDT_W'(DIV_WDT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WDT_W-1:0] WDT_ONE   = WDT_W'(1);

    // EX hold freezes PC, IF/ID, ID/EX and EX/MEM; bubble freezes up to ID/EX
    localparam logic [STALL_W-1:0] STALL_NONE   = '0;
    localparam logic [STALL_W-1:0] STALL_HOLD   = STALL_W'(4'b1111);
    localparam logic [STALL_W-1:0] STALL_BUBBLE = STALL_W'(3'b111);

    localparam logic [31:0] CYC_MAX = 32'hFFFF_FFFF;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WDT_W-1:0]   r_wdt;
    logic               r_timeout;
    logic [31:0]        r_stall_cycles;

    logic [1:0]         w_next_state;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WDT_W-1:0]   w_wdt_nxt;
    logic               w_timeout_set;
    logic [STALL_W-1:0] w_stall;

    // Next-state, counter updates and the same-cycle stall response
    always_comb begin
        w_next_state  = r_state;
        w_cnt_nxt     = r_cnt;
        w_wdt_nxt     = r_wdt;
        w_timeout_set = 1'b0;
        w_stall       = STALL_NONE;
        if (rst) begin
            // Reset overrides every request; registers are cleared below
            w_stall = STALL_NONE;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // md_start wins over the load-use request: the EX hold
                    // already freezes ID, so the bubble would be redundant
                    if (md_start) begin
                        w_stall = STALL_HOLD;
                        if (md_is_div) begin
                            w_next_state = ST_DIV;
                            w_wdt_nxt    = '0;
                        end else begin
                            w_next_state = ST_MUL;
                            w_cnt_nxt    = CNT_START;
                        end
                    end else if (stallreq_id) begin
                        w_stall = STALL_BUBBLE;
                    end else begin
                        w_stall = STALL_NONE;
                    end
                end
                ST_MUL: begin
                    if (r_cnt != '0) begin
                        w_stall   = STALL_HOLD;
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end else begin
                        // Release cycle: EX result latches into EX/MEM while
                        // md_start is still high, so we must not re-sample it
                        w_stall      = STALL_NONE;
                        w_next_state = ST_RUN;
                    end
                end
                ST_DIV: begin
                    if (md_done) begin
                        w_stall      = STALL_NONE;
                        w_next_state = ST_RUN;
                    end else if (r_wdt == WDT_LAST) begin
                        // Divider never answered: release the pipe anyway
                        w_stall       = STALL_NONE;
                        w_timeout_set = 1'b1;
                        w_next_state  = ST_RUN;
                    end else begin
                        w_stall   = STALL_HOLD;
                        w_wdt_nxt = r_wdt + WDT_ONE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to RUN without stalling
                    w_stall      = STALL_NONE;
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    // Sequencer state, counters, sticky watchdog flag and stall statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_cnt          <= '0;
            r_wdt          <= '0;
            r_timeout      <= 1'b0;
            r_stall_cycles <= 32'd0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_cnt_nxt;
            r_wdt     <= w_wdt_nxt;
            r_timeout <= r_timeout | w_timeout_set;
            if (w_stall[0] && (r_stall_cycles != CYC_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
        end
    end

    assign stall        = w_stall;
    assign md_busy      = ~rst & (r_state != ST_RUN);
    assign md_timeout   = r_timeout;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stall_ctrl
//
// Self-checking bench for stall_ctrl (STALL_W=6, MUL_CYCLES=3, DIV_WDT=64).
// Each cycle the driver pushes the expected stall/busy/count/timeout for that
// cycle onto a scoreboard queue; the scenario tasks pop and compare mid-cycle.
// ---------------------------------------------------------------------------
module tb_stall_ctrl;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_HOLD = 6'b001111;
    localparam logic [5:0] S_BUB  = 6'b000111;

    typedef struct packed {
        logic [5:0]  stall;
        logic        busy;
        logic [31:0] cyc;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id;
    logic        md_start;
    logic        md_is_div;
    logic        md_done;
    logic [5:0]  stall;
    logic        md_busy;
    logic        md_timeout;
    logic [31:0] stall_cycles;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_cyc = 32'd0;
    logic        model_to  = 1'b0;

    stall_ctrl #(.STALL_W(6), .MUL_CYCLES(3), .DIV_WDT(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .md_start     (md_start),
        .md_is_div    (md_is_div),
        .md_done      (md_done),
        .stall        (stall),
        .md_busy      (md_busy),
        .md_timeout   (md_timeout),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the edge and queue its expectation.
    // Counter/timeout expectations are the values visible during this cycle;
    // the model then advances to what the next cycle should show.
    task automatic drive(input logic r, input logic sq, input logic st,
                         input logic dv, input logic dn,
                         input logic [5:0] es, input logic eb);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stallreq_id = sq; md_start = st; md_is_div = dv; md_done = dn;
        e.stall = es; e.busy = eb; e.cyc = model_cyc; e.to = model_to;
        exp_q.push_back(e);
        if (r) begin
            model_cyc = 32'd0;
            model_to  = 1'b0;
        end else if (es[0]) begin
            model_cyc = model_cyc + 32'd1;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b1, 1'b1, c[0], 1'b1, S_NONE, 1'b0);
            #3;
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || md_busy !== e.busy || stall_cycles !== e.cyc || md_timeout !== e.to) begin
                failures++;
                $display("FAIL reset c=%0d stall=%b exp=%b busy=%b exp=%b cyc=%0d exp=%0d to=%b exp=%b",
                         c, stall, e.stall, md_busy, e.busy, stall_cycles, e.cyc, md_timeout, e.to);
            end
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, (c == 1), 1'b0, 1'b0, 1'b0, (c == 1) ? S_BUB : S_NONE, 1'b0);
            #3;
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || md_busy !== e.busy || stall_cycles !== e.cyc || md_timeout !== e.to) begin
                failures++;
                $display("FAIL load_use c=%0d stall=%b exp=%b busy=%b exp=%b cyc=%0d exp=%0d to=%b exp=%b",
                         c, stall, e.stall, md_busy, e.busy, stall_cycles, e.cyc, md_timeout, e.to);
            end
        end
    endtask

    // md_start held through the release cycle must not restart the multiply
    task automatic test_mul();
        exp_t e;
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, (c < 3), 1'b0, 1'b0, (c < 2) ? S_HOLD : S_NONE, (c == 1 || c == 2));
            #3;
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || md_busy !== e.busy || stall_cycles !== e.cyc || md_timeout !== e.to) begin
                failures++;
                $display("FAIL mul c=%0d stall=%b exp=%b busy=%b exp=%b cyc=%0d exp=%0d to=%b exp=%b",
                         c, stall, e.stall, md_busy, e.busy, stall_cycles, e.cyc, md_timeout, e.to);
            end
        end
    endtask

    // stallreq_id held high: md_start wins, ignored while busy and in release
    task automatic test_priority();
        exp_t       e;
        logic [5:0] es;
        for (int c = 0; c < 5; c++) begin
            if (c < 2)       es = S_HOLD;
            else if (c == 2) es = S_NONE;
            else if (c == 3) es = S_BUB;
            else             es = S_NONE;
            drive(1'b0, (c < 4), (c < 3), 1'b0, (c == 1), es, (c == 1 || c == 2));
            #3;
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || md_busy !== e.busy || stall_cycles !== e.cyc || md_timeout !== e.to) begin
                failures++;
                $display("FAIL priority c=%0d stall=%b exp=%b busy=%b exp=%b cyc=%0d exp=%0d to=%b exp=%b",
                         c, stall, e.stall, md_busy, e.busy, stall_cycles, e.cyc, md_timeout, e.to);
            end
        end
    endtask

    // Cycle 0 pulses md_done in RUN (ignored); divide accepted on cycle 1,
    // md_done on cycle 34 releases the pipe
    task automatic test_div();
        exp_t e;
        for (int c = 0; c < 36; c++) begin
            drive(1'b0, 1'b0, (c >= 1 && c <= 34), 1'b1, (c == 0 || c == 34),
                  (c >= 1 && c <= 33) ? S_HOLD : S_NONE, (c >= 2 && c <= 34));
            #3;
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || md_busy !== e.busy || stall_cycles !== e.cyc || md_timeout !== e.to) begin
                failures++;
                $display("FAIL div c=%0d stall=%b exp=%b busy=%b exp=%b cyc=%0d exp=%0d to=%b exp=%b",
                         c, stall, e.stall, md_busy, e.busy, stall_cycles, e.cyc, md_timeout, e.to);
            end
        end
    endtask

    // Multiply release cycle followed directly by a divide in RUN
    task automatic test_back_to_back();
        exp_t       e;
        logic [5:0] es;
        for (int c = 0; c < 7; c++) begin
            es = (c == 0 || c == 1 || c == 3 || c == 4) ? S_HOLD : S_NONE;
            drive(1'b0, 1'b0, (c <= 5), (c >= 3), (c == 5), es,
                  (c == 1 || c == 2 || c == 4 || c == 5));
            #3;
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || md_busy !== e.busy || stall_cycles !== e.cyc || md_timeout !== e.to) begin
                failures++;
                $display("FAIL back_to_back c=%0d stall=%b exp=%b busy=%b exp=%b cyc=%0d exp=%0d to=%b exp=%b",
                         c, stall, e.stall, md_busy, e.busy, stall_cycles, e.cyc, md_timeout, e.to);
            end
        end
    endtask

    // Divide accepted on cycle 1, DIV_BUSY with wdt=0..63 on cycles 2..65:
    // 64 stalled cycles, release on cycle 65, timeout visible from cycle 66.
    // A later multiply must leave the sticky flag set.
    task automatic test_watchdog();
        exp_t e;
        for (int c = 1; c <= 70; c++) begin
            if (c <= 66) begin
                drive(1'b0, 1'b0, (c <= 65), 1'b1, 1'b0,
                      (c <= 64) ? S_HOLD : S_NONE, (c >= 2 && c <= 65));
            end else begin
                drive(1'b0, 1'b0, (c <= 69), 1'b0, 1'b0,
                      (c <= 68) ? S_HOLD : S_NONE, (c == 68 || c == 69));
            end
            if (c == 65) model_to = 1'b1;
            #3;
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || md_busy !== e.busy || stall_cycles !== e.cyc || md_timeout !== e.to) begin
                failures++;
                $display("FAIL watchdog c=%0d stall=%b exp=%b busy=%b exp=%b cyc=%0d exp=%0d to=%b exp=%b",
                         c, stall, e.stall, md_busy, e.busy, stall_cycles, e.cyc, md_timeout, e.to);
            end
        end
    endtask

    // Reset for one cycle during DIV_BUSY with stallreq_id high
    task automatic test_reset_mid();
        exp_t e;
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4)       drive(1'b0, (c >= 2), 1'b1, 1'b1, 1'b0, S_HOLD, (c >= 2));
            else if (c == 5)  drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, S_NONE, 1'b0);
            else              drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_NONE, 1'b0);
            #3;
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || md_busy !== e.busy || stall_cycles !== e.cyc || md_timeout !== e.to) begin
                failures++;
                $display("FAIL reset_mid c=%0d stall=%b exp=%b busy=%b exp=%b cyc=%0d exp=%0d to=%b exp=%b",
                         c, stall, e.stall, md_busy, e.busy, stall_cycles, e.cyc, md_timeout, e.to);
            end
        end
    endtask

    initial begin
        rst = 1'b1; stallreq_id = 1'b1; md_start = 1'b1; md_is_div = 1'b0; md_done = 1'b0;
        test_reset();
        test_load_use();
        test_mul();
        test_priority();
        test_div();
        test_back_to_back();
        test_watchdog();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
